// File: rtl/masar_seq_mult_pkg.sv
// Shared definitions for the masar sequential multiplier.
//   DEF_WIDTH / DEF_DIGIT : default operand width and bits retired per BUSY cycle
//   state_e               : FSM state encoding (Idle=0, Busy=1, Done=2)
//   cnt_width()           : width of a down-counter that must hold n-1 (never below 1 bit)
package masar_seq_mult_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DIGIT = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/masar_seq_mult_digit_pp.sv
// Combinational WIDTH x DIGIT unsigned partial product.
//   a : WIDTH-bit multiplicand magnitude
//   b : DIGIT-bit slice of the multiplier
//   p : WIDTH+DIGIT-bit product a*b
module masar_seq_mult_digit_pp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [DIGIT-1:0]       b,
  output logic [WIDTH+DIGIT-1:0] p
);

  always_comb begin
    p = {{DIGIT{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  end

endmodule

// File: rtl/masar_seq_mult.sv
// Sequential shift-and-add multiplier, signed or unsigned, DIGIT multiplier bits per cycle.
// Operands are taken as magnitudes; the sign is re-applied once the last digit is summed.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only when idle)
//   in_signed, x, y      : operand mode and WIDTH-bit operands
//   out_valid / out_ready: result handshake (result held while out_valid)
//   result               : 2*WIDTH-bit product, keeps last value when idle
//   busy                 : high while digits are being accumulated
// WIDTH must be a multiple of DIGIT.
module masar_seq_mult
  import masar_seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIGIT = DEF_DIGIT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = cnt_width(N);
  localparam int unsigned AccW = 2 * WIDTH;
  localparam int unsigned ShW  = $clog2(AccW) + 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  xmag_q, xmag_d;
  logic [WIDTH-1:0]  ysh_q, ysh_d;
  logic              neg_q, neg_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [AccW-1:0]   result_q, result_d;

  logic [WIDTH+DIGIT-1:0] pp;
  logic [AccW-1:0]        pp_ext;
  logic [AccW-1:0]        acc_sum;
  logic [ShW-1:0]         shamt;

  // Most-negative input maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  masar_seq_mult_digit_pp #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_digit_pp (
    .a (xmag_q),
    .b (ysh_q[DIGIT-1:0]),
    .p (pp)
  );

  // Digit k = N-1-cnt is weighted by 2^(DIGIT*k).
  always_comb begin
    shamt   = ShW'((N - 1 - int'(cnt_q)) * DIGIT);
    pp_ext  = AccW'(pp);
    acc_sum = acc_q + (pp_ext << shamt);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xmag_d   = xmag_q;
    ysh_d    = ysh_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          xmag_d  = magnitude(x, in_signed);
          ysh_d   = magnitude(y, in_signed);
          neg_d   = in_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = CntW'(N - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d = acc_sum;
        ysh_d = ysh_q >> DIGIT;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          result_d = neg_q ? (~acc_sum + AccW'(1)) : acc_sum;
          cnt_d    = '0;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      xmag_q   <= '0;
      ysh_q    <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xmag_q   <= xmag_d;
      ysh_q    <= ysh_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q == StBusy);
    out_valid = (state_q == StDone);
    result    = result_q;
  end

endmodule

// File: tb/tb_masar_seq_mult.sv
// Directed self-checking bench for masar_seq_mult (WIDTH=8, DIGIT=2).
module tb_masar_seq_mult;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_signed = 1'b0;
  logic [7:0]  x = '0;
  logic [7:0]  y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  masar_seq_mult #(
    .WIDTH (8),
    .DIGIT (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        sg;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] golden(input logic sg, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    logic [15:0] ua, ub;
    sa = $signed({{8{a[7]}}, a});
    sb = $signed({{8{b[7]}}, b});
    ua = {8'b0, a};
    ub = {8'b0, b};
    return sg ? 16'(sa * sb) : 16'(ua * ub);
  endfunction

  // Starts from idle; returns result and cycles from accept edge to out_valid.
  task automatic do_op(input logic sg, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] r, output int lat);
    in_valid  = 1'b1;
    in_signed = sg;
    x = a;
    y = b;
    step();
    in_valid  = 1'b0;
    // scramble operands while busy; they must not matter
    x = 8'($urandom);
    y = 8'($urandom);
    in_signed = ~sg;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    chk("in_ready_while_busy", {31'b0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    r = result;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    int lat;
    int last_acc;

    tbl[0] = '{1'b0, 8'd55,  8'd63,  16'h0D89};
    tbl[1] = '{1'b1, 8'hFD,  8'd22,  16'hFFBE};
    tbl[2] = '{1'b1, 8'h80,  8'h80,  16'h4000};
    tbl[3] = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
    tbl[4] = '{1'b0, 8'h00,  8'h00,  16'h0000};
    tbl[5] = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
    tbl[6] = '{1'b1, 8'h7F,  8'h80,  16'hC080};
    tbl[7] = '{1'b0, 8'h80,  8'h02,  16'h0100};
    tbl[8] = '{1'b1, 8'd100, 8'd3,   16'h012C};
    tbl[9] = '{1'b1, 8'h00,  8'hFB,  16'h0000};

    // reset state
    #2;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_result", {16'b0, result}, 32'd0);
    #20;
    rst_n = 1'b1;
    step();

    // table of directed products with latency check
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].sg, tbl[i].a, tbl[i].b, r, lat);
      chk($sformatf("vec%0d_result", i), {16'b0, r}, {16'b0, tbl[i].exp});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      chk($sformatf("vec%0d_idle_after", i), {31'b0, in_ready}, 32'd1);
    end

    // stall in DONE with out_ready low; a new in_valid must be ignored
    in_valid = 1'b1; in_signed = 1'b0; x = 8'd126; y = 8'd69;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("stall_latency", 32'(lat), 32'(LAT));
    in_valid = 1'b1; x = 8'd3; y = 8'd5;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_result", {16'b0, result}, 32'h21F6);
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("stall_release_out_valid", {31'b0, out_valid}, 32'd0);
    chk("stall_release_in_ready", {31'b0, in_ready}, 32'd1);
    chk("stall_release_result_kept", {16'b0, result}, 32'h21F6);
    step();
    chk("stall_ignored_op_not_started", {31'b0, busy}, 32'd0);

    // reset during the 2nd busy cycle
    in_valid = 1'b1; in_signed = 1'b0; x = 8'd200; y = 8'd201;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_result", {16'b0, result}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("abort_no_result", {31'b0, out_valid}, 32'd0);
    end
    do_op(1'b0, 8'd23, 8'd124, r, lat);
    chk("post_abort_result", {16'b0, r}, 32'h0B24);
    chk("post_abort_latency", 32'(lat), 32'(LAT));

    // back-to-back with in_valid and out_ready tied high; early out_ready is harmless
    out_ready = 1'b1;
    in_valid  = 1'b1;
    last_acc  = -1;
    for (int i = 0; i < 1000; i++) begin
      logic sg;
      logic [7:0] a, b;
      int guard;
      sg = 1'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      in_signed = sg; x = a; y = b;
      guard = 0;
      while (!in_ready && guard < 20) begin
        step();
        guard++;
      end
      if (last_acc >= 0) chk("b2b_interval", 32'(cyc - last_acc), 32'(LAT + 2));
      last_acc = cyc;
      step();
      x = 8'($urandom); y = 8'($urandom); in_signed = ~sg;
      lat = 0;
      while (!out_valid && lat < 20) begin
        step();
        lat++;
      end
      chk("b2b_latency", 32'(lat), 32'(LAT));
      chk("b2b_result", {16'b0, result}, {16'b0, golden(sg, a, b)});
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
